io_tx_fifo_frame: RTL and testbench

IO_TX_FIFO_FRAME -- requirements
Module: io_tx_fifo_frame

---
 rtl/io_tx_fifo_frame.sv | 129 ++++++++++++
 tb/tb_io_tx_fifo_frame.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_tx_fifo_frame.sv
// io_tx_fifo_frame: fetch requester with framed FWFT response buffer.
// Ports: clk_i/rstn_i (async low), clr_i sync clear; req_o/gnt_i fetch
// handshake tagged by sof_i/eof_i; valid_i/data_i/ready_o response in;
// valid_o/data_o/sof_o/eof_o/ready_i stream out; elements_o fill,
// frames_o stored eof words, err_o protocol error.
// Optional macro IO_TX_FIFO_FRAME_ERR_EN builds the sticky error flag.
module io_tx_fifo_frame #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 4,
  parameter int MAX_INFLIGHT     = 2,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      clr_i,
  output logic                      req_o,
  input  logic                      gnt_i,
  input  logic                      sof_i,
  input  logic                      eof_i,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      sof_o,
  output logic                      eof_o,
  input  logic                      ready_i,
  output logic [LOG_BUFFER_DEPTH:0] elements_o,
  output logic [LOG_BUFFER_DEPTH:0] frames_o,
  output logic                      err_o
);

  localparam int CW = LOG_BUFFER_DEPTH + 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam int MW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [MW-1:0] MQ_LAST = MW'(MAX_INFLIGHT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_INFLIGHT);

  logic [EW-1:0]               mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]               inflight, drain, free;
  logic [1:0]                  mq [MAX_INFLIGHT];
  logic [MW-1:0]               mq_wr, mq_rd;
  logic [EW-1:0]               head;
  logic [1:0]                  mark;

  logic full, pop, draining;
  logic gnt_acc, rsp_acc, expected, push;

  assign head     = mem[rd_ptr];
  assign mark     = mq[mq_rd];
  assign full     = (elements_o == DEPTH_C);
  assign draining = (drain != '0);
  assign valid_o  = (elements_o != '0);
  assign pop      = valid_o & ready_i;
  assign data_o   = head[DATA_WIDTH-1:0];
  assign sof_o    = valid_o & head[DATA_WIDTH];
  assign eof_o    = valid_o & head[EW-1];

  // Full FIFO can still take a word when the head leaves this cycle.
  assign ready_o  = draining | ~full | pop;
  assign free     = DEPTH_C - elements_o;

  // Slots are reserved at grant time, so a response never overflows.
  assign req_o    = rstn_i & ~clr_i & ~draining
                  & (free > inflight) & (inflight < MAX_C);

  assign gnt_acc  = req_o & gnt_i;
  assign rsp_acc  = valid_i & ready_o;
  assign expected = rsp_acc & ~draining & (inflight != '0);
  assign push     = expected & ~clr_i;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {mark[1], mark[0], data_i};
  end

  always_ff @(posedge clk_i) begin
    if (gnt_acc) mq[mq_wr] <= {eof_i, sof_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      elements_o <= '0;
      frames_o   <= '0;
      inflight   <= '0;
      drain      <= '0;
      mq_wr      <= '0;
      mq_rd      <= '0;
    end else if (clr_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      elements_o <= '0;
      frames_o   <= '0;
      inflight   <= '0;
      mq_wr      <= '0;
      mq_rd      <= '0;
      // Outstanding grants still owe responses; swallow them later.
      drain      <= drain + inflight
                  - CW'(rsp_acc & (draining | (inflight != '0)));
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      elements_o <= elements_o + CW'(push) - CW'(pop);
      frames_o   <= frames_o + CW'(push & mark[1])
                  - CW'(pop & head[EW-1]);
      inflight   <= inflight + CW'(gnt_acc) - CW'(expected);
      if (draining & rsp_acc) drain <= drain - 1'b1;
      if (gnt_acc) mq_wr <= (mq_wr == MQ_LAST) ? '0 : mq_wr + 1'b1;
      if (expected) mq_rd <= (mq_rd == MQ_LAST) ? '0 : mq_rd + 1'b1;
    end
  end

`ifdef IO_TX_FIFO_FRAME_ERR_EN
  logic unexp;
  assign unexp = rsp_acc & ~draining & (inflight == '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                     err_o <= 1'b0;
    else if (clr_i)                  err_o <= 1'b0;
    else if (unexp | (gnt_i & ~req_o)) err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_io_tx_fifo_frame.sv
// tb_io_tx_fifo_frame: directed + random checks of io_tx_fifo_frame
// against a queue-based reference model.
module tb_io_tx_fifo_frame;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MAXI  = 2;
  localparam int LW    = $clog2(DEPTH);
`ifdef IO_TX_FIFO_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn_i = 1'b0;
  logic clr_i = 1'b0, gnt_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
  logic valid_i = 1'b0, ready_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic req_o, ready_o, valid_o, sof_o, eof_o, err_o;
  logic [DW-1:0] data_o;
  logic [LW:0] elements_o, frames_o;

  io_tx_fifo_frame #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .clr_i(clr_i),
    .req_o(req_o), .gnt_i(gnt_i), .sof_i(sof_i), .eof_i(eof_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .sof_o(sof_o), .eof_o(eof_o),
    .ready_i(ready_i), .elements_o(elements_o), .frames_o(frames_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } word_t;

  word_t      fifo_q[$];
  logic [1:0] mark_q[$];
  int         inflight, drain;
  bit         merr;
  int         checks, errors;

  function automatic bit m_req(bit c);
    return !c && drain == 0
        && (DEPTH - fifo_q.size() > inflight) && inflight < MAXI;
  endfunction

  function automatic int m_frames();
    int n = 0;
    foreach (fifo_q[i]) if (fifo_q[i].e) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    fifo_q.delete();
    mark_q.delete();
    inflight = 0;
    drain    = 0;
    merr     = 1'b0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    {clr_i, gnt_i, sof_i, eof_i, valid_i, ready_i} = '0;
    m_reset();
    @(negedge clk); #1;
    chk("rst_req", DW'(req_o), 0);
    chk("rst_valid", DW'(valid_o), 0);
    chk("rst_sof", DW'(sof_o), 0);
    chk("rst_eof", DW'(eof_o), 0);
    chk("rst_elem", DW'(elements_o), 0);
    chk("rst_frames", DW'(frames_o), 0);
    chk("rst_err", DW'(err_o), 0);
    rstn_i = 1'b1;
    #1;
    chk("rel_ready", DW'(ready_o), 1);
  endtask

  task automatic step(input bit c, g, s, e, v,
                      input logic [DW-1:0] d, input bit r);
    bit er, erdy, gacc, racc, pop;
    int outst;
    word_t w;
    @(negedge clk);
    clr_i = c; gnt_i = g; sof_i = s; eof_i = e;
    valid_i = v; data_i = d; ready_i = r;
    #1;
    er   = m_req(c);
    erdy = drain != 0 || fifo_q.size() < DEPTH
        || (fifo_q.size() > 0 && r);
    chk("req_o", DW'(req_o), DW'(er));
    chk("ready_o", DW'(ready_o), DW'(erdy));
    chk("valid_o", DW'(valid_o), DW'(fifo_q.size() != 0));
    chk("elements_o", DW'(elements_o), DW'(fifo_q.size()));
    chk("frames_o", DW'(frames_o), DW'(m_frames()));
    chk("err_o", DW'(err_o), DW'(merr && ERR_EN));
    if (fifo_q.size() != 0) begin
      chk("data_o", data_o, fifo_q[0].d);
      chk("sof_o", DW'(sof_o), DW'(fifo_q[0].s));
      chk("eof_o", DW'(eof_o), DW'(fifo_q[0].e));
    end
    @(posedge clk);
    gacc = er && g;
    racc = v && erdy;
    pop  = fifo_q.size() != 0 && r;
    if (c) begin
      outst = drain + inflight;
      if (racc && outst > 0) outst--;
      drain = outst;
      inflight = 0;
      fifo_q.delete();
      mark_q.delete();
      merr = 1'b0;
    end else begin
      if (ERR_EN && ((racc && drain == 0 && inflight == 0) || (g && !er)))
        merr = 1'b1;
      if (pop) void'(fifo_q.pop_front());
      if (racc) begin
        if (drain > 0) drain--;
        else if (inflight > 0) begin
          w.d = d;
          {w.e, w.s} = mark_q.pop_front();
          fifo_q.push_back(w);
          inflight--;
        end
      end
      if (gacc) begin
        mark_q.push_back({e, s});
        inflight++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();

    // three grants in a row, limit of two outstanding
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 0, 1);
    chk("lim_elem", DW'(elements_o), 0);
    step(0, 0, 0, 0, 1, 32'hA0, 1);
    step(0, 0, 0, 0, 1, 32'hB0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // grant and response in the same cycle with one outstanding
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 32'h11, 0);
    step(0, 0, 0, 0, 1, 32'h22, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // fill four with the stream stalled, then release one word
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 1, 32'h100 + i, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);

    // clear with two outstanding, both late responses swallowed
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'hDEAD, 1);
    step(0, 0, 0, 0, 1, 32'hBEEF, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // unexpected response, sticky until clear
    step(0, 0, 0, 0, 1, 32'h55, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // frames: sof,-,eof,sof,eof with stalled output
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'hA, 0);
    step(0, 1, 0, 1, 1, 32'hB, 0);
    step(0, 0, 0, 0, 1, 32'hC, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hD, 1);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hE, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1);

    // reset with grants outstanding: no drain afterwards
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    do_reset();
    step(0, 0, 0, 0, 1, 32'h77, 1);
    step(0, 0, 0, 0, 1, 32'h78, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 3) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
